// File: rtl/jtag_dpi_pkg.sv
// Shared constants and host-side entry points for the JTAG DPI bridge.
// A scripted in-language stand-in replays pin vectors and records the TDO it is handed.
package jtag_dpi_pkg;

  localparam int          DEFAULT_PORT     = 44853;
  localparam int unsigned DEFAULT_TICK_DIV = 10;

  // Handles are slot index + 1 so that 0 can stand in for a null context.
  typedef int unsigned ctx_t;

  localparam int unsigned StubMax    = 4;
  localparam int unsigned StubLen    = 64;
  localparam int unsigned StubLogLen = 512;
  localparam int unsigned StubIdxW   = $clog2(StubMax);
  localparam int unsigned StubLenW   = $clog2(StubLen);
  localparam int unsigned StubLogW   = $clog2(StubLogLen);

  typedef logic [StubIdxW-1:0] stub_idx_t;

  // Pin vectors are packed as {tck, tms, tdi, trst_n, srst_n}.
  int unsigned stub_handles     = 0;
  int unsigned stub_creates     = 0;
  int unsigned stub_closes      = 0;
  int unsigned stub_total_calls = 0;
  int          stub_port    [StubMax];
  logic [4:0]  stub_pins    [StubMax];
  logic [4:0]  stub_script  [StubMax][StubLen];
  int unsigned stub_len     [StubMax];
  int unsigned stub_calls   [StubMax];
  bit          stub_tdo_log [StubMax][StubLogLen];

  // Port 0 models a server that failed to open, so the caller gets a null context.
  function automatic ctx_t jtagdpi_create(input string name, input int listen_port);
    stub_idx_t h;
    stub_creates++;
    if (listen_port == 0 || name.len() == 0 || stub_handles >= StubMax) return '0;
    h = stub_idx_t'(stub_handles);
    stub_handles++;
    stub_port[h]  = listen_port;
    stub_pins[h]  = 5'b01011;
    stub_len[h]   = 0;
    stub_calls[h] = 0;
    return ctx_t'(stub_handles);
  endfunction

  // Once the script runs out the previous pins are returned, like an idle client.
  function automatic void jtagdpi_tick(
    input  ctx_t ctx,
    output bit   tck,
    output bit   tms,
    output bit   tdi,
    output bit   trst_n,
    output bit   srst_n,
    input  bit   tdo
  );
    stub_idx_t h;
    h = stub_idx_t'(ctx - 1);
    if (stub_calls[h] < stub_len[h] && stub_calls[h] < StubLen) begin
      stub_pins[h] = stub_script[h][StubLenW'(stub_calls[h])];
    end
    if (stub_calls[h] < StubLogLen) begin
      stub_tdo_log[h][StubLogW'(stub_calls[h])] = tdo;
    end
    stub_calls[h]++;
    stub_total_calls++;
    {tck, tms, tdi, trst_n, srst_n} = stub_pins[h];
  endfunction

  function automatic void jtagdpi_close(input ctx_t ctx);
    if (ctx != 0) stub_closes++;
  endfunction

  function automatic bit ctx_valid(input ctx_t ctx);
    return ctx != 0;
  endfunction

endpackage

// File: rtl/jtag_dpi_tick_gen.sv
// Poll divider: one-cycle tick every TickDiv clocks, counting restarts from reset.
module jtag_dpi_tick_gen
  import jtag_dpi_pkg::*;
#(
  parameter int unsigned TickDiv = DEFAULT_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick
);

  localparam int unsigned     CntW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  if (TickDiv < 2) begin : gen_bad_div
    $error("jtag_dpi_tick_gen: TickDiv must be at least 2");
  end

  logic [CntW-1:0] cnt_q;

  // Gating on rst_ni keeps a tick from coinciding with reset.
  assign tick = rst_ni && (cnt_q == CntMax);

  // Free-running modulo-TickDiv counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_dpi.sv
// Simulation bridge: polls a host debugger every TickDiv clocks and drives JTAG pins.
module jtag_dpi
  import jtag_dpi_pkg::*;
#(
  parameter string       Name       = "jtag0",
  parameter int          ListenPort = DEFAULT_PORT,
  parameter int unsigned TickDiv    = DEFAULT_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic jtag_tck,
  output logic jtag_tms,
  output logic jtag_tdi,
  input  logic jtag_tdo,
  output logic jtag_trst_n,
  output logic jtag_srst_n
);

  // Context survives resets; the host connection is opened exactly once.
  ctx_t ctx;

  initial ctx = jtagdpi_create(Name, ListenPort);

  final begin
    if (ctx_valid(ctx)) jtagdpi_close(ctx);
  end

  logic tick;

  jtag_dpi_tick_gen #(
    .TickDiv(TickDiv)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick  (tick)
  );

  logic tck_q, tms_q, tdi_q, trst_n_q, srst_n_q, tdo_q;
  bit   dpi_tck, dpi_tms, dpi_tdi, dpi_trst_n, dpi_srst_n;

  // Pins only move on the edge that ends a tick cycle; X on TDO reaches the host as 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      trst_n_q <= 1'b0;
      srst_n_q <= 1'b1;
      tdo_q    <= 1'b0;
    end else begin
      tdo_q <= jtag_tdo;
      if (!ctx_valid(ctx)) begin
        tck_q    <= 1'b0;
        tms_q    <= 1'b1;
        tdi_q    <= 1'b0;
        trst_n_q <= 1'b1;
        srst_n_q <= 1'b1;
      end else if (tick) begin
        jtagdpi_tick(ctx, dpi_tck, dpi_tms, dpi_tdi, dpi_trst_n, dpi_srst_n, tdo_q === 1'b1);
        tck_q    <= dpi_tck;
        tms_q    <= dpi_tms;
        tdi_q    <= dpi_tdi;
        trst_n_q <= dpi_trst_n;
        srst_n_q <= dpi_srst_n;
      end
    end
  end

  assign jtag_tck    = tck_q;
  assign jtag_tms    = tms_q;
  assign jtag_tdi    = tdi_q;
  assign jtag_trst_n = trst_n_q;
  assign jtag_srst_n = srst_n_q;

endmodule

// File: tb/tb_jtag_dpi.sv
// Bench for jtag_dpi: three instances (default divider, divider 4, null context)
// compared every cycle against a poll-schedule model driven by random TDO.
module tb_jtag_dpi;
  import jtag_dpi_pkg::*;

  // Pin vectors {tck, tms, tdi, trst_n, srst_n}.
  localparam logic [4:0] PinsReset   = 5'b01001;
  localparam logic [4:0] PinsIdle    = 5'b01011;
  localparam int         TdA         = 10;
  localparam int         TdB         = 4;
  localparam int         LenA        = 8;
  localparam int         LenB        = 40;
  localparam int         PortB       = 44854;
  localparam int         TotalCycles = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic tdo_a, tdo_b, tdo_n;
  logic a_tck, a_tms, a_tdi, a_trst_n, a_srst_n;
  logic b_tck, b_tms, b_tdi, b_trst_n, b_srst_n;
  logic n_tck, n_tms, n_tdi, n_trst_n, n_srst_n;

  jtag_dpi #(.Name("jtag_main"), .ListenPort(DEFAULT_PORT), .TickDiv(TdA)) u_main (
    .clk_i(clk), .rst_ni(rst_a), .jtag_tck(a_tck), .jtag_tms(a_tms), .jtag_tdi(a_tdi),
    .jtag_tdo(tdo_a), .jtag_trst_n(a_trst_n), .jtag_srst_n(a_srst_n)
  );

  jtag_dpi #(.Name("jtag_fast"), .ListenPort(PortB), .TickDiv(TdB)) u_fast (
    .clk_i(clk), .rst_ni(rst_b), .jtag_tck(b_tck), .jtag_tms(b_tms), .jtag_tdi(b_tdi),
    .jtag_tdo(tdo_b), .jtag_trst_n(b_trst_n), .jtag_srst_n(b_srst_n)
  );

  jtag_dpi #(.Name("jtag_null"), .ListenPort(0), .TickDiv(TdA)) u_null (
    .clk_i(clk), .rst_ni(rst_b), .jtag_tck(n_tck), .jtag_tms(n_tms), .jtag_tdi(n_tdi),
    .jtag_tdo(tdo_n), .jtag_trst_n(n_trst_n), .jtag_srst_n(n_srst_n)
  );

  logic [4:0] obs_a, obs_b, obs_n;
  assign obs_a = {a_tck, a_tms, a_tdi, a_trst_n, a_srst_n};
  assign obs_b = {b_tck, b_tms, b_tdi, b_trst_n, b_srst_n};
  assign obs_n = {n_tck, n_tms, n_tdi, n_trst_n, n_srst_n};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int h_a    = -1;
  int h_b    = -1;

  logic [4:0] scr_a [LenA];
  logic [4:0] scr_b [LenB];

  // Reference model: edges since release, calls made, expected pins, and the TDO the
  // host must see (value present at the edge before each poll).
  int         k_a = 0, k_b = 0, calls_a = 0, calls_b = 0;
  logic [4:0] pins_a = PinsReset, pins_b = PinsReset, pins_n = PinsReset;
  bit         last_a = 1'b0, last_b = 1'b0;
  bit         exp_a [$];
  bit         exp_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    int unsigned r;
    r     = $urandom_range(0, 7);
    tdo_a = (r == 0) ? 1'bx : r[0];
    tdo_b = 1'($urandom_range(0, 1));
    tdo_n = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst_a) begin
      k_a++;
      if (k_a % TdA == 0) begin
        exp_a.push_back(last_a);
        if (calls_a < LenA) pins_a = scr_a[calls_a];
        calls_a++;
      end
      last_a = (tdo_a === 1'b1);
    end
    if (rst_b) begin
      k_b++;
      if (k_b % TdB == 0) begin
        exp_b.push_back(last_b);
        if (calls_b < LenB) pins_b = scr_b[calls_b];
        calls_b++;
      end
      last_b = (tdo_b === 1'b1);
      pins_n = PinsIdle;
    end
    @(negedge clk);
    cyc++;
    chk("main_pins", 32'(obs_a), 32'(pins_a));
    chk("fast_pins", 32'(obs_b), 32'(pins_b));
    chk("null_pins", 32'(obs_n), 32'(pins_n));
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    tdo_a = 1'b0;
    tdo_b = 1'b0;
    tdo_n = 1'b0;
    #1;
    for (int h = 0; h < int'(stub_handles); h++) begin
      if (stub_port[h] == DEFAULT_PORT) h_a = h;
      if (stub_port[h] == PortB) h_b = h;
    end
    chk("main_handle_found", 32'(h_a >= 0), 32'd1);
    chk("fast_handle_found", 32'(h_b >= 0), 32'd1);
    if (h_a < 0 || h_b < 0) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end

    // Main script: first poll drives tck=1,tms=0,tdi=1,trst_n=1; third poll pulses srst_n.
    scr_a[0] = 5'b10111;
    for (int i = 1; i < LenA; i++) begin
      scr_a[i] = {3'($urandom_range(0, 7)), 1'b1, (i == 2) ? 1'b0 : 1'b1};
    end
    // Fast script toggles tck on every poll.
    for (int i = 0; i < LenB; i++) begin
      scr_b[i] = {(i % 2 == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)), 2'b11};
    end
    for (int i = 0; i < LenA; i++) stub_script[h_a][i] = scr_a[i];
    for (int i = 0; i < LenB; i++) stub_script[h_b][i] = scr_b[i];
    stub_len[h_a] = LenA;
    stub_len[h_b] = LenB;

    repeat (3) cycle();
    rst_a = 1'b1;
    rst_b = 1'b1;
    while (k_a != 35) cycle();

    // Mid-period reset (divider at 5): pins must drop without waiting for a clock.
    #2;
    rst_a  = 1'b0;
    k_a    = 0;
    last_a = 1'b0;
    pins_a = PinsReset;
    #1;
    chk("main_async_reset", 32'(obs_a), 32'(PinsReset));
    repeat (3) cycle();
    rst_a = 1'b1;

    while (cyc < TotalCycles) cycle();

    chk("create_count", stub_creates, 32'd3);
    chk("open_handles", stub_handles, 32'd2);
    chk("main_call_count", stub_calls[h_a], 32'(calls_a));
    chk("fast_call_count", stub_calls[h_b], 32'(calls_b));
    chk("total_calls_null_silent", stub_total_calls, 32'(calls_a + calls_b));
    for (int i = 0; i < exp_a.size() && i < int'(StubLogLen); i++) begin
      chk("main_tdo_seen", 32'(stub_tdo_log[h_a][i]), 32'(exp_a[i]));
    end
    for (int i = 0; i < exp_b.size() && i < int'(StubLogLen); i++) begin
      chk("fast_tdo_seen", 32'(stub_tdo_log[h_b][i]), 32'(exp_b[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
